// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate engine: captures a selected operand and amount,
// then shifts one bit per cycle and pulses done when the result is valid.
module shift_engine #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2,
    parameter int AMT_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic                     amt_sel,
    input  logic [AMT_W-1:0]         amt_in,
    input  logic [2:0]               op,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  operand;
    logic [AMT_W-1:0]  amount;
    logic [WIDTH-1:0]  shifted;
    logic [AMT_W-1:0]  cnt;
    logic [2:0]        op_q;

    // Out-of-range selectors fall through to an all-zero operand.
    always_comb begin
        operand = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                operand = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign amount = amt_sel ? operand[AMT_W-1:0] : amt_in;

    always_comb begin
        shifted = result;
        case (op_q)
            OP_SLL:  shifted = {result[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, result[WIDTH-1:1]};
            OP_SRA:  shifted = {result[WIDTH-1], result[WIDTH-1:1]};
            OP_ROR:  shifted = {result[0], result[WIDTH-1:1]};
            OP_ROL:  shifted = {result[WIDTH-2:0], result[WIDTH-1]};
            default: shifted = result;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (amount != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == AMT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            cnt    <= '0;
            op_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        result <= operand;
                        cnt    <= amount;
                        op_q   <= op;
                    end
                end
                SHIFT: begin
                    result <= shifted;
                    cnt    <= cnt - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits (legal range 2..64).
REQ-002 Parameter NUM_SRC, default 3, number of selectable shift-input sources (legal range 2..8).
REQ-003 Parameter SEL_W, default 2, source-selector width; SHALL satisfy 2^SEL_W >= NUM_SRC.
REQ-004 Parameter AMT_W, default 5, shift-amount width; SHALL equal ceil(log2(WIDTH)).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to begin one shift operation.
REQ-008 src_sel  input  SEL_W  selects the operand source.
REQ-009 src_data  input  NUM_SRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-010 amt_sel  input  1  0: amount from amt_in; 1: amount from low AMT_W bits of the selected source.
REQ-011 amt_in  input  AMT_W  explicit shift amount.
REQ-012 op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others PASS.
REQ-013 busy  output  1  high while an operation is in progress (states LOAD-accepted through DONE).
REQ-014 done  output  1  one-cycle pulse marking a valid result.
REQ-015 result  output  WIDTH  shift result register.

Function
REQ-016 Operand mux SHALL return source src_sel when src_sel < NUM_SRC, else all-zero operand.
REQ-017 FSM states IDLE, SHIFT, DONE; the reset state SHALL be IDLE.
REQ-018 In IDLE with start=1 (cycle T), the engine SHALL capture the operand into result, the amount into a down-counter cnt, and op into an op register.
REQ-019 After capture: next state SHIFT if amount != 0, else DONE.
REQ-020 In SHIFT, each cycle SHALL shift result by exactly one bit per latched op and decrement cnt; when cnt==1 the next state SHALL be DONE.
REQ-021 SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates MSB; ROR moves LSB to MSB; ROL moves MSB to LSB; PASS leaves result unchanged while still counting.
REQ-022 Latency: done SHALL be high exactly in cycle T+1+amount; amount 0 gives done in T+1.
REQ-023 In DONE, done=1 for that single cycle and next state SHALL be IDLE.
REQ-024 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored; no queuing.
REQ-026 start in the IDLE cycle directly following DONE SHALL be accepted normally (back-to-back ops, one idle cycle between).
REQ-027 result SHALL hold its value in IDLE until the next accepted start.
REQ-028 Changes on src_sel, src_data, amt_in, op after capture SHALL NOT affect the running operation.
REQ-029 amt_sel=1 with an invalid src_sel SHALL yield amount 0.

Reset
REQ-030 reset=1 at a rising edge SHALL force state IDLE, result=0, cnt=0, done=0, busy=0, regardless of state.
REQ-031 reset SHALL take priority over start in the same cycle; the operation SHALL NOT be accepted.
REQ-032 Reset mid-SHIFT SHALL abort with no done pulse.

Verification
REQ-033 WIDTH=32: src 1=0x0000_00F1, src_sel=1, amt_in=4, op SLL, start -> done at T+5, result=0x0000_0F10.
REQ-034 src 0=0x8000_0010, op SRA, amt_in=4 -> result=0xF800_0001; same with op SRL -> 0x0800_0001; op ROR amt 8 on 0x1234_5678 -> 0x7812_3456.
REQ-035 src_sel=3 (NUM_SRC=3), amt_in=0 -> done at T+1, result=0x0000_0000.
REQ-036 amt_sel=1, src 2=0x0000_0023, op ROL -> amount 3, done at T+4, result=0x0000_0118.
REQ-037 start pulsed again during SHIFT and op/src changed -> ignored, original result produced; reset asserted during SHIFT -> result=0, busy=0, no done.
REQ-038 Back-to-back: start held high continuously with amt 1 -> done every third cycle, busy low only in the accepting IDLE cycles.
